// File: rtl/fir_pkg.sv
// Constants and helpers shared by the FIR datapath and its sample buffering.
package fir_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FIFO_DEPTH = 16;

    // Ceiling log2, usable in parameter and port declarations.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Sample storage: DEPTH x DATA_W register array, one synchronous write port
// and one asynchronous read port.
module fifo_mem
    import fir_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [clog2(DEPTH)-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [clog2(DEPTH)-1:0]  rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with fill count, threshold flags, sticky error
// flags, synchronous flush and selectable registered / FWFT read.
module sample_fifo
    import fir_pkg::*;
#(
    parameter int DATA_W   = SAMPLE_W,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    full,
    output logic                    almost_full,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic                    empty,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sample_fifo: DEPTH must be a power of two and at least 2");
        end
        if (!((AE_LEVEL > 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
            $error("sample_fifo: thresholds must satisfy 0 < AE_LEVEL < AF_LEVEL <= DEPTH");
        end
    endgenerate

    logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              af_q, af_d;
    logic              empty_q, empty_d;
    logic              ae_q, ae_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] mem_rd;

    // Flush wins over traffic: neither side is accepted nor flagged.
    always_comb begin
        wr_acc   = wr_en & ~full_q & ~clr;
        rd_acc   = rd_en & ~empty_q & ~clr;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_acc};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_acc};
        ovf_d    = ovf_q | (wr_en & full_q);
        unf_d    = unf_q | (rd_en & empty_q);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end
        count_d = wr_ptr_d - rd_ptr_d;
        full_d  = (count_d == DEPTH_C);
        af_d    = (count_d >= AF_C);
        empty_d = (count_d == '0);
        ae_d    = (count_d <= AE_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            empty_q  <= 1'b1;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            af_q     <= af_d;
            empty_q  <= empty_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (mem_rd)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; zero while empty so reset reads 0.
            assign rd_data  = empty_q ? '0 : mem_rd;
            assign rd_valid = ~empty_q;
        end else begin : g_std
            logic [DATA_W-1:0] rd_data_q, rd_data_d;
            logic              rd_valid_q, rd_valid_d;

            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = rd_acc;
                if (rd_acc) begin
                    rd_data_d = mem_rd;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

    assign full         = full_q;
    assign almost_full  = af_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Bench for sample_fifo: a registered-read and an FWFT instance share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_sample_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;

    logic          s_full, s_af, s_rd_valid, s_empty, s_ae, s_ovf, s_unf;
    logic [DW-1:0] s_rd_data;
    logic [2:0]    s_count;
    logic          f_full, f_af, f_rd_valid, f_empty, f_ae, f_ovf, f_unf;
    logic [DW-1:0] f_rd_data;
    logic [2:0]    f_count;

    always #5 clk = ~clk;

    sample_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .full(s_full), .almost_full(s_af), .rd_en(rd_en), .rd_data(s_rd_data),
        .rd_valid(s_rd_valid), .empty(s_empty), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sample_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .full(f_full), .almost_full(f_af), .rd_en(rd_en), .rd_data(f_rd_data),
        .rd_valid(f_rd_valid), .empty(f_empty), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;
    bit log_en = 0;
    bit verbose = 1;
    logic [DW-1:0] got[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: occupancy is a queue, errors are plain sticky bits.
    logic [DW-1:0] mq[$];
    bit            m_ovf, m_unf, m_sv;
    logic [DW-1:0] m_sd;

    always @(posedge clk or negedge rst_n) begin : model
        bit was_full;
        bit was_empty;
        if (!rst_n) begin
            mq.delete();
            m_ovf = 0; m_unf = 0; m_sv = 0; m_sd = '0;
        end else if (clr) begin
            mq.delete();
            m_ovf = 0; m_unf = 0; m_sv = 0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            m_sv = 0;
            if (wr_en && was_full) m_ovf = 1;
            if (rd_en && was_empty) m_unf = 1;
            if (rd_en && !was_empty) begin
                m_sd = mq.pop_front();
                m_sv = 1;
            end
            if (wr_en && !was_full) mq.push_back(wr_data);
        end
    end

    always @(negedge clk) begin : compare
        int sz;
        if (chk_en) begin
            sz = mq.size();
            chk("std_count", 32'(s_count), 32'(sz));
            chk("std_empty", 32'(s_empty), 32'(sz == 0));
            chk("std_full", 32'(s_full), 32'(sz == DEPTH));
            chk("std_af", 32'(s_af), 32'(sz >= AF));
            chk("std_ae", 32'(s_ae), 32'(sz <= AE));
            chk("std_ovf", 32'(s_ovf), 32'(m_ovf));
            chk("std_unf", 32'(s_unf), 32'(m_unf));
            chk("std_rd_valid", 32'(s_rd_valid), 32'(m_sv));
            chk("std_rd_data", 32'(s_rd_data), 32'(m_sd));
            chk("fwft_count", 32'(f_count), 32'(sz));
            chk("fwft_flags", 32'({f_empty, f_full, f_af, f_ae, f_ovf, f_unf}),
                32'({sz == 0, sz == DEPTH, sz >= AF, sz <= AE, m_ovf, m_unf}));
            chk("fwft_rd_valid", 32'(f_rd_valid), 32'(sz != 0));
            if (sz != 0) chk("fwft_rd_data", 32'(f_rd_data), 32'(mq[0]));
            if (log_en && s_rd_valid) got.push_back(s_rd_data);
        end
    end

    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        wr_en = w; wr_data = d; rd_en = r; clr = c;
        @(posedge clk);
        @(negedge clk);
        wr_en = 0; rd_en = 0; clr = 0;
        if (verbose)
            $display("txn t=%0t wr=%0b data=%04h rd=%0b clr=%0b -> count=%0d rd_valid=%0b rd_data=%04h",
                     $time, w, d, r, c, s_count, s_rd_valid, s_rd_data);
    endtask

    initial begin
        rst_n = 0; clr = 0; wr_en = 0; rd_en = 0; wr_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        chk_en = 1;
        step(0, 0, 0, 0);
        chk("rst_count", 32'(s_count), 0);
        chk("rst_empty_ae", 32'({s_empty, s_ae}), 32'h3);
        chk("rst_full_af", 32'({s_full, s_af}), 0);
        chk("rst_errs", 32'({s_ovf, s_unf, f_ovf, f_unf}), 0);
        chk("rst_rd", 32'({s_rd_valid, f_rd_valid}), 0);
        chk("rst_rd_data", 32'(s_rd_data), 0);

        // Fill 1..4
        for (int i = 1; i <= 4; i++) begin
            step(1, 16'(i), 0, 0);
            chk("fill_count", 32'(s_count), 32'(i));
            chk("fill_af", 32'(s_af), 32'(i >= 3));
            chk("fill_full", 32'(s_full), 32'(i == 4));
        end
        step(1, 16'd9, 0, 0);
        chk("ovf_count", 32'(s_count), 4);
        chk("ovf_flag", 32'(s_ovf), 1);

        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 1, 0);
            chk("drain_valid", 32'(s_rd_valid), 1);
            chk("drain_data", 32'(s_rd_data), 32'(i));
            step(0, 0, 0, 0);
            chk("drain_pulse", 32'(s_rd_valid), 0);
        end
        step(0, 0, 1, 0);
        chk("unf_flag", 32'(s_unf), 1);
        chk("unf_count", 32'(s_count), 0);
        step(0, 0, 0, 0);
        chk("sticky", 32'({s_ovf, s_unf}), 32'h3);
        step(0, 0, 0, 1);
        chk("clr_errs", 32'({s_ovf, s_unf}), 0);

        // Stream 0..11 at a steady count of 2
        log_en = 1;
        step(1, 16'd0, 0, 0);
        step(1, 16'd1, 0, 0);
        for (int i = 2; i < 12; i++) begin
            step(1, 16'(i), 1, 0);
            chk("stream_count", 32'(s_count), 2);
        end
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        log_en = 0;
        chk("stream_len", 32'(got.size()), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < got.size()) chk("stream_order", 32'(got[i]), 32'(i));
        end

        // FWFT presentation and pop
        step(1, 16'hA5A5, 0, 0);
        chk("fwft_valid", 32'(f_rd_valid), 1);
        chk("fwft_data", 32'(f_rd_data), 32'hA5A5);
        step(0, 0, 1, 0);
        chk("fwft_pop", 32'({f_empty, f_rd_valid}), 32'h2);

        // clr beats a same-cycle write
        for (int i = 0; i < 5; i++) step(1, 16'(16'h10 + i), 0, 0);
        step(0, 0, 1, 0);
        chk("pre_clr_count", 32'(s_count), 3);
        chk("pre_clr_ovf", 32'(s_ovf), 1);
        step(1, 16'h77, 0, 1);
        chk("clr_count", 32'(s_count), 0);
        chk("clr_ovf", 32'(s_ovf), 0);
        step(0, 0, 0, 0);
        chk("clr_nowrite", 32'(s_empty), 1);

        // Randomised traffic
        verbose = 0;
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) < 5,
                 $urandom_range(0, 63) == 0);
        end
        verbose = 1;

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) step(1, 16'(16'h40 + i), 0, 0);
        step(0, 0, 1, 0);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_count", 32'({s_count, f_count}), 0);
        chk("arst_flags", 32'({s_empty, s_ae, s_full, s_af, s_ovf, s_unf}), 32'h30);
        chk("arst_rd", 32'({s_rd_valid, f_rd_valid}), 0);
        chk("arst_rd_data", 32'(s_rd_data), 0);
        @(negedge clk);
        rst_n = 1;
        step(0, 0, 0, 0);
        chk("post_arst_empty", 32'(s_empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sample_fifo.md
Name: sample_fifo

Overview:
- Single-clock, parametrised sample FIFO that buffers FIR input/output samples between a producer (ADC/decimator front end) and the filter datapath.
- Successor to the fixed 16-bit dual-clock FIFO. It adds configurable width and depth, a fill count, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, a synchronous flush, and an optional first-word-fall-through (FWFT) read mode.

Parameters:
- DATA_W, 16, sample width in bits.
- DEPTH, 16, number of entries; power of two, at least 2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0, 0 = registered read (standard), 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush of contents and error flags.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write sample.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- rd_en  in  1  read or pop request.
- rd_data  out  DATA_W  read sample.
- rd_valid  out  1  rd_data holds a valid sample.
- empty  out  1  count == 0.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers, count, overflow, underflow, rd_valid and rd_data are all 0.
  - empty=1, almost_empty=1, full=0, almost_full=0 (given AF_LEVEL >= 1).
  - Memory contents are don't-care.
- Pointers: wr_ptr and rd_ptr are clog2(DEPTH)+1 bits wide. The MSB is the wrap bit and the low bits address memory. Both increment modulo 2*DEPTH.
- count is wr_ptr - rd_ptr, registered. All status flags are registered and are derived from next-state count, so they are valid in the same cycle as count.
- Write accept = wr_en & !full. When accepted, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read accept = rd_en & !empty. When accepted, rd_ptr increments.
- Full plus simultaneous read and write: the write is rejected and overflow is set; the read proceeds. There is no pass-through.
- Empty plus simultaneous read and write: the read is rejected and underflow is set; the write proceeds.
- Simultaneous accepted read and write: count is unchanged.
- Standard mode (FWFT=0):
  - On an accepted read, rd_data <= mem[rd_ptr] at the next edge and rd_valid pulses high for exactly 1 cycle. Latency is 1 cycle.
  - rd_data holds its last value otherwise.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally and rd_valid = !empty.
  - rd_en acts as a pop/acknowledge.
  - A word written into an empty FIFO appears on rd_data the cycle after the write edge.
- Error flags: overflow and underflow are sticky. Only clr or reset clears them.
- clr:
  - Next edge: pointers, count, error flags and rd_valid go to 0, and the flags return to their reset values.
  - clr has priority over a same-cycle wr_en or rd_en; both are ignored without setting any error flag.
- Reset asserted mid-operation clears state immediately. No partial write may survive.
- Elaboration-time checks: DEPTH must be a power of two, and 0 < AE_LEVEL < AF_LEVEL <= DEPTH. Otherwise elaboration fails via a generate-time error.

Decomposition:
- Shared package fir_pkg holds SAMPLE_W (16), the default FIFO depth, and a clog2 constant function used by this block and the FIR datapath.
- One sub-module, fifo_mem: a DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port.
- sample_fifo owns the pointers, count, flags and the read-mode generate branch.

Test Plan:
- Reset then idle, DEPTH=4: after rst_n deasserts, count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0.
- Fill and drain, DEPTH=4, AF=3, AE=1, FWFT=0:
  - Write 1,2,3,4: count steps 1..4; almost_full asserts at count 3; full asserts at 4.
  - Read 4 times: rd_data = 1,2,3,4, each 1 cycle after rd_en, with a single-cycle rd_valid pulse each time.
- Overflow and underflow:
  - With the FIFO full, wr_en with data 9 leaves count=4 and sets overflow=1; the data is never read out.
  - Drain to empty, then rd_en sets underflow=1 with count=0.
  - Both flags stay set until clr.
- Simultaneous traffic and wrap: stream 0..11 through DEPTH=4 with wr_en and rd_en high together at count=2. count stays 2, the output order is exactly 0..11, and the pointer wrap is exercised 3 times.
- FWFT=1: write 0xA5A5 into an empty FIFO. The next cycle rd_valid=1 and rd_data=0xA5A5. rd_en pops it, giving empty=1 and rd_valid=0 the following cycle.
- Mid-operation control:
  - With count=3 and overflow set, assert clr with wr_en=1: next cycle count=0, overflow=0, no write stored.
  - Then pulse rst_n low between clock edges: outputs go to reset values immediately, without waiting for clk.
